// File: rtl/busca_de_instrucao.sv
// busca_de_instrucao: instruction fetch stage with IF/ID register, stall, redirect and misalignment fault
module busca_de_instrucao #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [31:0] address,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fault,
    output logic [31:0] fetch_count
);
    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] pc;
    logic        live;
    logic        redir_ok;
    logic        redir_bad;
    logic        cap;

    assign address     = pc;
    assign id_pc_plus4 = id_pc + 32'd4;
    assign live        = state != FAULT;
    assign redir_ok    = live && redirect_valid && redirect_target[1:0] == 2'b00;
    assign redir_bad   = live && redirect_valid && redirect_target[1:0] != 2'b00;
    assign cap         = state == RUN && enable && !redirect_valid && (!id_valid || id_ready);

    // redirect outranks capture; FAULT freezes everything until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            pc             <= PC0;
            id_valid       <= 1'b0;
            id_instruction <= '0;
            id_pc          <= '0;
            fault          <= 1'b0;
            fetch_count    <= '0;
        end else if (redir_bad) begin
            state    <= FAULT;
            fault    <= 1'b1;
            id_valid <= 1'b0;
        end else if (live) begin
            state <= enable ? RUN : IDLE;
            if (redir_ok) begin
                pc       <= redirect_target;
                id_valid <= 1'b0;
            end else if (cap) begin
                id_instruction <= instruction;
                id_pc          <= pc;
                id_valid       <= 1'b1;
                pc             <= pc + 32'd4;
                fetch_count    <= fetch_count + 32'd1;
            end else if (id_ready) begin
                id_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/busca_de_instrucao.md
# busca_de_instrucao

Instruction fetch stage: the requester side of the instruction memory port. Holds the program counter, drives the word address to the combinational instruction memory, captures the returned instruction word into the IF/ID pipeline register, and hands it to decode over a valid/ready handshake. Supports stall (decode back-pressure), redirect (branch/jump target with flush), run/idle control, and a sticky fault on misaligned redirect targets.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] forced to 0.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable  in  1  fetch run request; low parks the fetcher in IDLE.
- address  out  32  byte address to instruction memory; equals pc, combinational from the register.
- instruction  in  32  word returned combinationally by instruction memory for `address`.
- redirect_valid  in  1  one-cycle request to load a new PC.
- redirect_target  in  32  new PC, byte address; must be word aligned.
- id_ready  in  1  decode accepts the IF/ID word this cycle.
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_instruction  out  32  captured instruction word.
- id_pc  out  32  address the captured word was fetched from.
- id_pc_plus4  out  32  id_pc + 4, modulo 2^32.
- fault  out  1  sticky misaligned-redirect flag.
- fetch_count  out  32  count of words captured into IF/ID, wraps modulo 2^32.

## Operation
- States: IDLE, RUN, FAULT. Reset enters IDLE.
- IDLE -> RUN when enable = 1. RUN -> IDLE when enable = 0. IDLE/RUN -> FAULT on misaligned redirect. FAULT exits only by reset.
- Capture condition (`cap`): state = RUN, enable = 1, redirect_valid = 0, and (id_valid = 0 or id_ready = 1).
- On `cap`: id_instruction <= instruction, id_pc <= pc, id_valid <= 1, pc <= pc + 4, fetch_count <= fetch_count + 1.
- If not `cap` and id_ready = 1, id_valid <= 0 (word consumed, no replacement).
- Stall: id_valid = 1 and id_ready = 0 -> pc, id_* and fetch_count hold.
- Redirect, aligned (redirect_target[1:0] = 0), in IDLE or RUN: pc <= redirect_target, id_valid <= 0 (flush, even if id_ready = 0). It has priority over capture and stall. The word at the old pc is discarded and not counted.
- Redirect, misaligned: state <= FAULT, fault <= 1, id_valid <= 0, pc unchanged.
- FAULT: no capture, redirect ignored, id_valid = 0, address holds the last pc.
- IDLE: no capture. A pending id_valid word still drains via id_ready. Redirect is honoured.
- Arithmetic: pc + 4 and fetch_count wrap modulo 2^32. 32'hFFFF_FFFC -> 32'h0000_0000.

## Timing
- Reset values: address = RESET_PC & ~3, id_valid = 0, id_instruction = 0, id_pc = 0, id_pc_plus4 = 4, fault = 0, fetch_count = 0, state IDLE.
- Reset mid-operation: all outputs return to reset values asynchronously. Any in-flight IF/ID word is lost.
- Latency: the word at address A appears on id_instruction one edge after A is driven, provided `cap` holds in that cycle.
- Throughput: one word per cycle while in RUN with id_ready = 1.
- Startup: enable is sampled high at edge 0 (IDLE -> RUN). First capture at edge 1. id_valid is high from edge 1.
- Redirect sampled at edge N: address = target in cycle N+1, id_valid = 0 in cycle N+1, first target word is valid after edge N+1.
- Redirect coincident with id_ready = 1 and a valid word: the decode handshake completes, the flush applies, and no new capture occurs.
- A handshake completes when id_valid = 1 and id_ready = 1 at a rising edge.

## Test plan
- Memory holds 20080001, 20090002, 01095020, AC0A0000 at words 0..3. Apply reset, then enable = 1 and id_ready = 1 -> id_instruction = 20080001 / 20090002 / 01095020 / AC0A0000 with id_pc = 0 / 4 / 8 / C on consecutive cycles. fetch_count = 4 after the 4th capture.
- Hold id_ready = 0 for 3 cycles after the first capture -> id_instruction stays 20080001, address stays 4, fetch_count stays 1. On release, 20090002 arrives next cycle.
- Redirect to 32'h0000_0008 while a word is valid and id_ready = 0 -> id_valid = 0 next cycle, then id_instruction = 01095020 with id_pc = 8. The discarded word is not counted.
- Redirect to 32'h0000_0006 -> fault = 1 and id_valid = 0 permanently. A later aligned redirect is ignored. Reset clears fault, and address returns to RESET_PC.
- Set RESET_PC = FFFF_FFFC with the memory returning 0 -> id_pc = FFFF_FFFC, then id_pc = 0000_0000, and id_pc_plus4 = 0000_0000 on the first capture.
- Assert reset mid-run with id_valid = 1 -> id_valid, fetch_count and fault drop to 0 and address = RESET_PC without waiting for a clock edge.
